cu_register_file: RTL and testbench
===================================

# cu_register_file

Compute-unit register file at the far end of the crossbar's write path. Accepts the single write port (`xb_rf_w_En`, `xb_rf_dt`) driven by the crossbar and serves the two read ports (`rf_xb_dtx`, `rf_xb_dty`) back to it, addressed by the program sequencer. Also provides a sequenced clear-all operation, a busy indication and a dropped-write flag for the sequencer. Read-after-write bypass stays in the crossbar; this block provides plain old-value reads.

## Interface
Parameters:
- `DATA_WIDTH`, 16, register width.
- `ADDRESS_WIDTH`, 4, address width; depth N = 2^ADDRESS_WIDTH.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ps_xb_wadd`  in  ADDRESS_WIDTH  write address from the sequencer, the same net the crossbar sees.
- `ps_xb_raddx`  in  ADDRESS_WIDTH  read address, port X.
- `ps_xb_raddy`  in  ADDRESS_WIDTH  read address, port Y.
- `xb_rf_w_En`  in  1  write enable from the crossbar.
- `xb_rf_dt`  in  DATA_WIDTH  write data from the crossbar.
- `ps_rf_clr`  in  1  clear-all request, sampled on the clock edge.
- `rf_xb_dtx`  out  DATA_WIDTH  port X read data (combinational).
- `rf_xb_dty`  out  DATA_WIDTH  port Y read data (combinational).
- `rf_ps_busy`  out  1  high while a clear is in progress (registered).
- `rf_ps_wdrop`  out  1  one-cycle pulse after a write that was discarded (registered).

## Operation
- Storage: N registers of DATA_WIDTH bits, each reset asynchronously to 0.
- Write: in IDLE, when `xb_rf_w_En`=1, `reg[ps_xb_wadd]` <= `xb_rf_dt` at the clock edge.
- Read: `rf_xb_dtx` = `reg[ps_xb_raddx]` and `rf_xb_dty` = `reg[ps_xb_raddy]`, purely combinational. Both ports can read the same address. A read of the address being written in the same cycle returns the old value.
- FSM with 2 states, IDLE and CLEAR, and a counter `clr_ptr` of ADDRESS_WIDTH bits:
  - IDLE -> CLEAR when `ps_rf_clr`=1. `clr_ptr` <= 0.
  - In CLEAR, each edge does `reg[clr_ptr]` <= 0 and `clr_ptr` <= `clr_ptr`+1.
  - CLEAR -> IDLE on the edge that clears address N-1. `clr_ptr` wraps to 0.
- `rf_ps_busy` = 1 exactly while the state is CLEAR.
- Writes while the state is CLEAR are discarded, and `rf_ps_wdrop` pulses high for one cycle on the next edge. `rf_ps_wdrop` is 0 otherwise.
- `ps_rf_clr` in CLEAR is ignored; there is no restart and no queueing.
- `ps_rf_clr` and a write at the same IDLE edge: the write is performed, and CLEAR starts on that same edge. The written register is still zeroed when `clr_ptr` reaches it. No drop is flagged.
- Reads during CLEAR return current contents: already-cleared registers read 0, the rest read their old values.

## Timing
- Write latency: data is visible on the read ports 1 cycle after the write edge.
- Clear: exactly N cycles with `rf_ps_busy`=1, starting at the edge after `ps_rf_clr` is sampled. The first write that is accepted is the one in the cycle after `rf_ps_busy` falls.
- Reset values:
  - All registers 0, so `rf_xb_dtx` and `rf_xb_dty` are 0.
  - `rf_ps_busy`=0 and `rf_ps_wdrop`=0.
  - State IDLE, `clr_ptr`=0.
- Reset asserted mid-clear aborts it immediately and zeroes everything asynchronously.

## Configuration
- `CU_RF_ZERO_REG_EN` defined: register 0 is hardwired to 0.
  - Writes to address 0 are ignored silently, with no `rf_ps_wdrop`.
  - Reads of address 0 always return 0.
- `CU_RF_ZERO_REG_EN` undefined: register 0 is an ordinary register.

## Test plan
- After reset: read x=3, y=15 -> both 0; `rf_ps_busy`=0, `rf_ps_wdrop`=0.
- Write 16'hA5A5 to address 5 with raddx=5 in the same cycle -> `rf_xb_dtx` shows the old value 0 in that cycle and 16'hA5A5 in the next cycle. Then set raddx=raddy=5 -> both 16'hA5A5.
- Fill all 16 addresses with addr*16'h1111, pulse `ps_rf_clr` -> `rf_ps_busy` high for 16 cycles. Mid-clear, address 2 reads 0 while address 12 still reads 16'hCCCC. Afterwards all addresses read 0.
- Write during cycle 4 of a clear -> the register is unchanged, and `rf_ps_wdrop`=1 for exactly one cycle. A second `ps_rf_clr` during the clear does not extend `rf_ps_busy` beyond 16 cycles.
- Assert `reset` at cycle 7 of a clear with nonzero registers -> `rf_ps_busy` drops immediately, and all reads return 0.
- With `CU_RF_ZERO_REG_EN`: write 16'hFFFF to address 0 -> x reads 0, `rf_ps_wdrop`=0. Without the macro -> x reads 16'hFFFF.

Source files
------------

// File: rtl/cu_register_file_if.sv
// -----------------------------------------------------------------------------
// cu_register_file_if
//   Bundles the crossbar/sequencer-facing signals of the compute-unit register
//   file.
//
//   Parameters
//     DATA_WIDTH    register width
//     ADDRESS_WIDTH address width (depth = 2**ADDRESS_WIDTH)
//
//   Signals (direction as seen by the register file, i.e. the slave modport)
//     ps_xb_wadd   in   write address from the sequencer
//     ps_xb_raddx  in   read address, port X
//     ps_xb_raddy  in   read address, port Y
//     xb_rf_w_En   in   write enable from the crossbar
//     xb_rf_dt     in   write data from the crossbar
//     ps_rf_clr    in   clear-all request
//     rf_xb_dtx    out  port X read data (combinational)
//     rf_xb_dty    out  port Y read data (combinational)
//     rf_ps_busy   out  clear in progress (registered)
//     rf_ps_wdrop  out  one-cycle pulse after a discarded write (registered)
//
//   master: the sequencer/crossbar side; slave: the register file.
// -----------------------------------------------------------------------------
interface cu_register_file_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4
);
    logic [ADDRESS_WIDTH-1:0] ps_xb_wadd;
    logic [ADDRESS_WIDTH-1:0] ps_xb_raddx;
    logic [ADDRESS_WIDTH-1:0] ps_xb_raddy;
    logic                     xb_rf_w_En;
    logic [DATA_WIDTH-1:0]    xb_rf_dt;
    logic                     ps_rf_clr;
    logic [DATA_WIDTH-1:0]    rf_xb_dtx;
    logic [DATA_WIDTH-1:0]    rf_xb_dty;
    logic                     rf_ps_busy;
    logic                     rf_ps_wdrop;

    modport master (
        output ps_xb_wadd,
        output ps_xb_raddx,
        output ps_xb_raddy,
        output xb_rf_w_En,
        output xb_rf_dt,
        output ps_rf_clr,
        input  rf_xb_dtx,
        input  rf_xb_dty,
        input  rf_ps_busy,
        input  rf_ps_wdrop
    );

    modport slave (
        input  ps_xb_wadd,
        input  ps_xb_raddx,
        input  ps_xb_raddy,
        input  xb_rf_w_En,
        input  xb_rf_dt,
        input  ps_rf_clr,
        output rf_xb_dtx,
        output rf_xb_dty,
        output rf_ps_busy,
        output rf_ps_wdrop
    );
endinterface

// File: rtl/cu_register_file.sv
// -----------------------------------------------------------------------------
// cu_register_file
//   Compute-unit register file: one write port from the crossbar, two
//   combinational read ports back to it, a sequenced clear-all (one register
//   per cycle), a busy flag and a dropped-write flag for the sequencer.
//   Reads return the stored (old) value; read-after-write bypass lives in the
//   crossbar.
//
//   Ports
//     clk    in  system clock, rising edge
//     reset  in  asynchronous, active-high reset
//     bus    cu_register_file_if.slave (write/read/clear/status signals)
//
//   Build option
//     CU_RF_ZERO_REG_EN  when defined, register 0 is hardwired to zero: writes
//                        to address 0 are silently ignored (no drop flag) and
//                        reads of address 0 return 0.
// -----------------------------------------------------------------------------
module cu_register_file #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    cu_register_file_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {ADDRESS_WIDTH{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0]    regs_q [DEPTH];
    logic [DATA_WIDTH-1:0]    regs_d [DEPTH];
    logic                     busy_q, busy_d;
    logic                     wdrop_q, wdrop_d;
    logic                     wr_allowed;

    // Address 0 may be a hardwired zero register; writes there vanish quietly.
    always_comb begin
`ifdef CU_RF_ZERO_REG_EN
        wr_allowed = (bus.ps_xb_wadd != '0);
`else
        wr_allowed = 1'b1;
`endif
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        regs_d    = regs_q;
        wdrop_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A write and a clear request on the same edge: the write
                // lands and the sweep still zeroes it later.
                if (bus.xb_rf_w_En && wr_allowed) begin
                    regs_d[bus.ps_xb_wadd] = bus.xb_rf_dt;
                end
                if (bus.ps_rf_clr) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                regs_d[clr_ptr_q] = '0;
                clr_ptr_d         = clr_ptr_q + 1'b1;  // wraps to 0 after last
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
                // Further clear requests are ignored; writes are dropped.
                if (bus.xb_rf_w_En) begin
                    wdrop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
            busy_q    <= 1'b0;
            wdrop_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            wdrop_q   <= wdrop_d;
            regs_q    <= regs_d;
        end
    end

    // Plain old-value reads; no bypass of the write in flight.
    always_comb begin
        bus.rf_xb_dtx = regs_q[bus.ps_xb_raddx];
        bus.rf_xb_dty = regs_q[bus.ps_xb_raddy];
`ifdef CU_RF_ZERO_REG_EN
        if (bus.ps_xb_raddx == '0) bus.rf_xb_dtx = '0;
        if (bus.ps_xb_raddy == '0) bus.rf_xb_dty = '0;
`endif
    end

    assign bus.rf_ps_busy  = busy_q;
    assign bus.rf_ps_wdrop = wdrop_q;

endmodule

// File: tb/tb_cu_register_file.sv
module tb_cu_register_file;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cu_register_file_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    cu_register_file #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ps_xb_wadd = a;
        bus.xb_rf_dt   = d;
        bus.xb_rf_w_En = 1'b1;
        tick();
        bus.xb_rf_w_En = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            write_reg(AW'(i), DW'(i) * 16'h1111);
        end
    endtask

    task automatic test_reset();
        bus.ps_xb_wadd  = '0;
        bus.ps_xb_raddx = 4'd3;
        bus.ps_xb_raddy = 4'd15;
        bus.xb_rf_w_En  = 1'b0;
        bus.xb_rf_dt    = '0;
        bus.ps_rf_clr   = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== 16'h0000) begin
            errors++; $display("FAIL reset_dtx: got %h want 0000", bus.rf_xb_dtx);
        end
        checks++;
        if (bus.rf_xb_dty !== 16'h0000) begin
            errors++; $display("FAIL reset_dty: got %h want 0000", bus.rf_xb_dty);
        end
        checks++;
        if (bus.rf_ps_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", bus.rf_ps_busy);
        end
        checks++;
        if (bus.rf_ps_wdrop !== 1'b0) begin
            errors++; $display("FAIL reset_wdrop: got %b want 0", bus.rf_ps_wdrop);
        end
    endtask

    task automatic test_write_read();
        bus.ps_xb_wadd  = 4'd5;
        bus.xb_rf_dt    = 16'hA5A5;
        bus.xb_rf_w_En  = 1'b1;
        bus.ps_xb_raddx = 4'd5;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== 16'h0000) begin
            errors++; $display("FAIL wr_same_cycle_old: got %h want 0000", bus.rf_xb_dtx);
        end
        tick();
        bus.xb_rf_w_En = 1'b0;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== 16'hA5A5) begin
            errors++; $display("FAIL wr_next_cycle: got %h want a5a5", bus.rf_xb_dtx);
        end
        bus.ps_xb_raddy = 4'd5;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== 16'hA5A5 || bus.rf_xb_dty !== 16'hA5A5) begin
            errors++; $display("FAIL wr_both_ports: got x=%h y=%h want a5a5", bus.rf_xb_dtx, bus.rf_xb_dty);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        fill_all();
        bus.ps_xb_raddx = 4'd12;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== 16'hCCCC) begin
            errors++; $display("FAIL fill_12: got %h want cccc", bus.rf_xb_dtx);
        end
        bus.ps_rf_clr = 1'b1;
        tick();
        bus.ps_rf_clr = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40 && bus.rf_ps_busy === 1'b1; c++) begin
            busy_cnt++;
            if (c == 3) begin
                bus.ps_xb_raddx = 4'd2;
                bus.ps_xb_raddy = 4'd12;
                #1;
                checks++;
                if (bus.rf_xb_dtx !== 16'h0000 || bus.rf_xb_dty !== 16'hCCCC) begin
                    errors++; $display("FAIL mid_clear: got x2=%h y12=%h want 0000 cccc", bus.rf_xb_dtx, bus.rf_xb_dty);
                end
            end
            tick();
        end
        checks++;
        if (busy_cnt !== 16) begin
            errors++; $display("FAIL clear_busy_len: got %0d cycles want 16", busy_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            bus.ps_xb_raddx = AW'(i);
            #1;
            checks++;
            if (bus.rf_xb_dtx !== 16'h0000) begin
                errors++; $display("FAIL after_clear_%0d: got %h want 0000", i, bus.rf_xb_dtx);
            end
        end
    endtask

    task automatic test_wdrop();
        int busy_cnt;
        write_reg(4'd14, 16'h1234);
        bus.ps_xb_raddx = 4'd14;
        bus.ps_rf_clr = 1'b1;
        tick();
        bus.ps_rf_clr = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40 && bus.rf_ps_busy === 1'b1; c++) begin
            busy_cnt++;
            if (c == 3) begin
                bus.ps_xb_wadd = 4'd14;
                bus.xb_rf_dt   = 16'hBEEF;
                bus.xb_rf_w_En = 1'b1;
                bus.ps_rf_clr  = 1'b1;
            end
            if (c == 4) begin
                bus.xb_rf_w_En = 1'b0;
                bus.ps_rf_clr  = 1'b0;
                checks++;
                if (bus.rf_ps_wdrop !== 1'b1) begin
                    errors++; $display("FAIL wdrop_pulse: got %b want 1", bus.rf_ps_wdrop);
                end
                checks++;
                if (bus.rf_xb_dtx !== 16'h1234) begin
                    errors++; $display("FAIL drop_unchanged: got %h want 1234", bus.rf_xb_dtx);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.rf_ps_wdrop !== 1'b0) begin
                    errors++; $display("FAIL wdrop_one_cycle: got %b want 0", bus.rf_ps_wdrop);
                end
            end
            tick();
        end
        checks++;
        if (busy_cnt !== 16) begin
            errors++; $display("FAIL reclear_busy_len: got %0d cycles want 16", busy_cnt);
        end
        // First write after busy falls is accepted.
        write_reg(4'd9, 16'h9999);
        bus.ps_xb_raddx = 4'd9;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== 16'h9999 || bus.rf_ps_wdrop !== 1'b0) begin
            errors++; $display("FAIL write_after_clear: got %h wdrop=%b want 9999 wdrop=0", bus.rf_xb_dtx, bus.rf_ps_wdrop);
        end
    endtask

    task automatic test_clear_with_write();
        int guard;
        bus.ps_xb_wadd  = 4'd3;
        bus.xb_rf_dt    = 16'h3333;
        bus.xb_rf_w_En  = 1'b1;
        bus.ps_rf_clr   = 1'b1;
        bus.ps_xb_raddx = 4'd3;
        tick();
        bus.xb_rf_w_En = 1'b0;
        bus.ps_rf_clr  = 1'b0;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== 16'h3333 || bus.rf_ps_busy !== 1'b1 || bus.rf_ps_wdrop !== 1'b0) begin
            errors++; $display("FAIL clr_and_write: got %h busy=%b wdrop=%b want 3333 1 0", bus.rf_xb_dtx, bus.rf_ps_busy, bus.rf_ps_wdrop);
        end
        guard = 0;
        while (bus.rf_ps_busy === 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (bus.rf_ps_busy !== 1'b0 || bus.rf_xb_dtx !== 16'h0000) begin
            errors++; $display("FAIL clr_and_write_end: got %h busy=%b want 0000 0", bus.rf_xb_dtx, bus.rf_ps_busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_all();
        bus.ps_rf_clr = 1'b1;
        tick();
        bus.ps_rf_clr = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        bus.ps_xb_raddx = 4'd10;
        bus.ps_xb_raddy = 4'd15;
        #1;
        checks++;
        if (bus.rf_ps_busy !== 1'b1 || bus.rf_xb_dtx !== 16'hAAAA || bus.rf_xb_dty !== 16'hFFFF) begin
            errors++; $display("FAIL pre_reset_state: got busy=%b x=%h y=%h want 1 aaaa ffff", bus.rf_ps_busy, bus.rf_xb_dtx, bus.rf_xb_dty);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.rf_ps_busy !== 1'b0 || bus.rf_xb_dtx !== 16'h0000 || bus.rf_xb_dty !== 16'h0000) begin
            errors++; $display("FAIL async_reset: got busy=%b x=%h y=%h want 0 0000 0000", bus.rf_ps_busy, bus.rf_xb_dtx, bus.rf_xb_dty);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bus.rf_ps_busy !== 1'b0) begin
            errors++; $display("FAIL reset_stays_idle: got busy=%b want 0", bus.rf_ps_busy);
        end
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] exp0;
`ifdef CU_RF_ZERO_REG_EN
        exp0 = 16'h0000;
`else
        exp0 = 16'hFFFF;
`endif
        write_reg(4'd0, 16'hFFFF);
        bus.ps_xb_raddx = 4'd0;
        #1;
        checks++;
        if (bus.rf_xb_dtx !== exp0) begin
            errors++; $display("FAIL zero_reg_read: got %h want %h", bus.rf_xb_dtx, exp0);
        end
        checks++;
        if (bus.rf_ps_wdrop !== 1'b0) begin
            errors++; $display("FAIL zero_reg_wdrop: got %b want 0", bus.rf_ps_wdrop);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_write_read();
        test_clear();
        test_wdrop();
        test_clear_with_write();
        test_reset_mid_clear();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
